// File: rtl/counter_run_ctrl_if.sv
// Command channel between the ui/uio decode logic and counter_run_ctrl.
// Carries a valid/ready handshake with a 2-bit opcode and a WIDTH-bit operand.
interface counter_run_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/counter_run_ctrl.sv
// Command-driven sequencer for the up-counter: CLEAR/LOAD/RUN/STOP, halts exactly on target and pulses done.
// Optional feature macro AUTO_RELOAD_EN: on reaching target, reload the counter and keep running until STOP.
module counter_run_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    counter_run_ctrl_if.slave    cmd,
    input  logic [WIDTH-1:0]     cnt_val,
    output logic                 cnt_clr,
    output logic                 cnt_load,
    output logic [WIDTH-1:0]     cnt_load_val,
    output logic                 cnt_en,
    output logic                 busy,
    output logic                 done
);

    localparam logic [1:0] OP_CLEAR = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_RUN   = 2'b10;
    localparam logic [1:0] OP_STOP  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DONE   = 2'd2
`ifdef AUTO_RELOAD_EN
        ,
        ST_RELOAD = 2'd3
`endif
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] target;
`ifdef AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload;
`endif

    logic             in_run_c;
    logic             is_stop_c;
    logic             accept_c;
    logic             at_target_c;
    logic [WIDTH-1:0] cnt_next_c;

`ifdef AUTO_RELOAD_EN
    assign in_run_c = (state == ST_RUN) || (state == ST_RELOAD);
`else
    assign in_run_c = (state == ST_RUN);
`endif

    assign is_stop_c     = (cmd.cmd_op == OP_STOP);
    assign cmd.cmd_ready = (state == ST_IDLE) || (in_run_c && is_stop_c);
    assign accept_c      = cmd.cmd_valid && cmd.cmd_ready;

    // Terminal test looks one increment ahead so the counter stops on target, not past it.
    assign cnt_next_c  = WIDTH'(cnt_val + WIDTH'(1));
    assign at_target_c = cnt_en && (cnt_next_c == target);

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            target       <= '0;
`ifdef AUTO_RELOAD_EN
            reload       <= '0;
`endif
            cnt_clr      <= 1'b0;
            cnt_load     <= 1'b0;
            cnt_load_val <= '0;
            cnt_en       <= 1'b0;
            done         <= 1'b0;
        end else begin
            // Strobes are single-cycle unless a state explicitly re-asserts them.
            cnt_clr  <= 1'b0;
            cnt_load <= 1'b0;
            done     <= 1'b0;

            case (state)
                ST_IDLE: begin
                    cnt_en <= 1'b0;
                    if (accept_c) begin
                        case (cmd.cmd_op)
                            OP_CLEAR: cnt_clr <= 1'b1;
                            OP_LOAD: begin
                                cnt_load     <= 1'b1;
                                cnt_load_val <= WIDTH'(cmd.cmd_data);
`ifdef AUTO_RELOAD_EN
                                reload       <= WIDTH'(cmd.cmd_data);
`endif
                            end
                            OP_RUN: begin
                                target <= WIDTH'(cmd.cmd_data);
                                if (WIDTH'(cmd.cmd_data) == cnt_val) begin
                                    state <= ST_DONE;
                                    done  <= 1'b1;
                                end else begin
                                    state  <= ST_RUN;
                                    cnt_en <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                ST_RUN: begin
                    if (accept_c) begin
                        state  <= ST_IDLE;
                        cnt_en <= 1'b0;
                    end else if (at_target_c) begin
                        cnt_en <= 1'b0;
                        done   <= 1'b1;
`ifdef AUTO_RELOAD_EN
                        state        <= ST_RELOAD;
                        cnt_load     <= 1'b1;
                        cnt_load_val <= reload;
`else
                        state        <= ST_DONE;
`endif
                    end
                end

`ifdef AUTO_RELOAD_EN
                ST_RELOAD: begin
                    if (accept_c) begin
                        state  <= ST_IDLE;
                        cnt_en <= 1'b0;
                    end else if (reload == target) begin
                        // Reload value already equals target: every cycle is a terminal cycle.
                        done         <= 1'b1;
                        cnt_load     <= 1'b1;
                        cnt_load_val <= reload;
                    end else begin
                        state  <= ST_RUN;
                        cnt_en <= 1'b1;
                    end
                end
`endif

                ST_DONE: begin
                    state  <= ST_IDLE;
                    cnt_en <= 1'b0;
                end

                default: begin
                    state  <= ST_IDLE;
                    cnt_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Directed testbench for counter_run_ctrl with a behavioural counter datapath.
module tb_counter_run_ctrl;

    localparam logic [1:0] OP_CLEAR = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_RUN   = 2'b10;
    localparam logic [1:0] OP_STOP  = 2'b11;

    logic       clk;
    logic       rst;
    logic [7:0] cnt_val;
    logic       cnt_clr;
    logic       cnt_load;
    logic [7:0] cnt_load_val;
    logic       cnt_en;
    logic       busy;
    logic       done;

    int n_checks;
    int n_fail;

    counter_run_ctrl_if #(.WIDTH(8)) cmd_if ();

    counter_run_ctrl #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd          (cmd_if),
        .cnt_val      (cnt_val),
        .cnt_clr      (cnt_clr),
        .cnt_load     (cnt_load),
        .cnt_load_val (cnt_load_val),
        .cnt_en       (cnt_en),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counter datapath: clr > load > en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           cnt_val <= 8'd0;
        else if (cnt_clr)  cnt_val <= 8'd0;
        else if (cnt_load) cnt_val <= cnt_load_val;
        else if (cnt_en)   cnt_val <= cnt_val + 8'd1;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present a command and hold it until accepted; returns 1 #1 after the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [7:0] data, output bit ok);
        int n;
        n = 0;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = op;
        cmd_if.cmd_data  = data;
        #1;
        while (cmd_if.cmd_ready !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        ok = (cmd_if.cmd_ready === 1'b1);
        @(posedge clk);
        #1;
        cmd_if.cmd_valid = 1'b0;
    endtask

    // Sample strobes for a fixed window, starting with the current sample.
    task automatic watch(input int cycles, output int en_cnt, output int done_cnt, output logic [7:0] done_val);
        en_cnt   = 0;
        done_cnt = 0;
        done_val = 8'hxx;
        for (int i = 0; i < cycles; i++) begin
            if (cnt_en === 1'b1) en_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                done_val = cnt_val;
            end
            step(1);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = OP_CLEAR;
        cmd_if.cmd_data  = 8'd0;
        #2;
        n_checks++;
        if ({cnt_clr, cnt_load, cnt_en, done, busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b expected 00000", {cnt_clr, cnt_load, cnt_en, done, busy});
        end
        n_checks++;
        if (cnt_load_val !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_load_val: got %0d expected 0", cnt_load_val);
        end
        #10 rst = 1'b0;
        #1;
        n_checks++;
        if (cmd_if.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b expected 1", cmd_if.cmd_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_run;
        bit ok;
        int n;
        issue(OP_CLEAR, 8'd0, ok);
        step(1);
        issue(OP_RUN, 8'd200, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL midrst_run_accept: got not accepted expected accepted");
        end
        n = 0;
        while (cnt_val !== 8'd37 && n < 100) begin
            step(1);
            n++;
        end
        n_checks++;
        if (cnt_val !== 8'd37 || cnt_en !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_reach37: got cnt %0d en %b expected 37 1", cnt_val, cnt_en);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({cnt_clr, cnt_load, cnt_en, done, busy} !== 5'b0 || cnt_load_val !== 8'd0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got %b/%0d expected 00000/0",
                     {cnt_clr, cnt_load, cnt_en, done, busy}, cnt_load_val);
        end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (cmd_if.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_ready: got %b expected 1", cmd_if.cmd_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_load_run;
        bit ok;
        int en_cnt, done_cnt;
        logic [7:0] dv;
        issue(OP_LOAD, 8'd5, ok);
        n_checks++;
        if (cnt_load !== 1'b1 || cnt_load_val !== 8'd5) begin
            n_fail++;
            $display("FAIL load5_strobe: got load %b val %0d expected 1 5", cnt_load, cnt_load_val);
        end
        step(1);
        n_checks++;
        if (cnt_load !== 1'b0 || cnt_val !== 8'd5) begin
            n_fail++;
            $display("FAIL load5_after: got load %b cnt %0d expected 0 5", cnt_load, cnt_val);
        end
        issue(OP_RUN, 8'd9, ok);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL run9_busy: got %b expected 1", busy);
        end
        watch(12, en_cnt, done_cnt, dv);
        n_checks++;
        if (en_cnt != 4) begin
            n_fail++;
            $display("FAIL run9_en_cycles: got %0d expected 4", en_cnt);
        end
        n_checks++;
        if (done_cnt != 1 || dv !== 8'd9) begin
            n_fail++;
            $display("FAIL run9_done: got %0d pulses at %0d expected 1 at 9", done_cnt, dv);
        end
        n_checks++;
        if (busy !== 1'b0 || cnt_val !== 8'd9) begin
            n_fail++;
            $display("FAIL run9_end: got busy %b cnt %0d expected 0 9", busy, cnt_val);
        end
    endtask

    task automatic test_zero_length;
        bit ok;
        int en_cnt, done_cnt;
        logic [7:0] dv;
        issue(OP_CLEAR, 8'd0, ok);
        n_checks++;
        if (cnt_clr !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_strobe: got %b expected 1", cnt_clr);
        end
        step(1);
        n_checks++;
        if (cnt_clr !== 1'b0 || cnt_val !== 8'd0) begin
            n_fail++;
            $display("FAIL clear_after: got clr %b cnt %0d expected 0 0", cnt_clr, cnt_val);
        end
        issue(OP_RUN, 8'd0, ok);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_run_done_now: got done %b busy %b expected 1 1", done, busy);
        end
        watch(5, en_cnt, done_cnt, dv);
        n_checks++;
        if (en_cnt != 0 || done_cnt != 1 || dv !== 8'd0) begin
            n_fail++;
            $display("FAIL zero_run: got en %0d done %0d at %0d expected 0 1 at 0", en_cnt, done_cnt, dv);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_run_idle: got busy %b expected 0", busy);
        end
    endtask

    task automatic test_wrap;
        bit ok;
        int en_cnt, done_cnt;
        logic [7:0] dv;
        issue(OP_LOAD, 8'd250, ok);
        step(1);
        issue(OP_RUN, 8'd3, ok);
        watch(20, en_cnt, done_cnt, dv);
        n_checks++;
        if (en_cnt != 9) begin
            n_fail++;
            $display("FAIL wrap_en_cycles: got %0d expected 9", en_cnt);
        end
        n_checks++;
        if (done_cnt != 1 || dv !== 8'd3 || cnt_val !== 8'd3) begin
            n_fail++;
            $display("FAIL wrap_halt: got %0d pulses at %0d final %0d expected 1 at 3 final 3", done_cnt, dv, cnt_val);
        end
    endtask

    task automatic test_stop_and_stall;
        bit ok;
        int n;
        int ready_seen;
        int done_seen;
        issue(OP_CLEAR, 8'd0, ok);
        step(1);
        issue(OP_RUN, 8'd100, ok);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = OP_LOAD;
        cmd_if.cmd_data  = 8'd7;
        #1;
        n = 0;
        ready_seen = 0;
        done_seen  = 0;
        while (cnt_val !== 8'd39 && n < 200) begin
            if (cmd_if.cmd_ready !== 1'b0) ready_seen++;
            if (done !== 1'b0) done_seen++;
            step(1);
            n++;
        end
        n_checks++;
        if (ready_seen != 0 || cnt_val !== 8'd39) begin
            n_fail++;
            $display("FAIL busy_load_stall: got ready %0d times cnt %0d expected 0 times cnt 39", ready_seen, cnt_val);
        end
        cmd_if.cmd_op = OP_STOP;
        #1;
        n_checks++;
        if (cmd_if.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stop_ready: got %b expected 1", cmd_if.cmd_ready);
        end
        @(posedge clk);
        #1;
        cmd_if.cmd_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || cnt_en !== 1'b0 || cnt_load !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_idle: got busy %b en %b load %b expected 0 0 0", busy, cnt_en, cnt_load);
        end
        for (int i = 0; i < 3; i++) begin
            if (done !== 1'b0) done_seen++;
            step(1);
        end
        n_checks++;
        if (cnt_val !== 8'd40 || done_seen != 0) begin
            n_fail++;
            $display("FAIL stop_hold: got cnt %0d done %0d expected 40 0", cnt_val, done_seen);
        end
        issue(OP_LOAD, 8'd7, ok);
        step(1);
        n_checks++;
        if (cnt_val !== 8'd7) begin
            n_fail++;
            $display("FAIL load_after_stop: got %0d expected 7", cnt_val);
        end
    endtask

`ifdef AUTO_RELOAD_EN
    task automatic test_auto_reload;
        bit ok;
        logic [7:0] exp_seq [12];
        logic exp_done;
        exp_seq = '{8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd2, 8'd3};
        issue(OP_LOAD, 8'd2, ok);
        step(1);
        issue(OP_RUN, 8'd6, ok);
        for (int i = 0; i < 12; i++) begin
            exp_done = (i == 4 || i == 9);
            n_checks++;
            if (cnt_val !== exp_seq[i] || done !== exp_done) begin
                n_fail++;
                $display("FAIL reload_seq[%0d]: got cnt %0d done %b expected %0d %b",
                         i, cnt_val, done, exp_seq[i], exp_done);
            end
            step(1);
        end
        issue(OP_STOP, 8'd0, ok);
        n_checks++;
        if (busy !== 1'b0 || cnt_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reload_stop: got busy %b en %b expected 0 0", busy, cnt_en);
        end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset;
        test_reset_mid_run;
`ifndef AUTO_RELOAD_EN
        test_load_run;
        test_wrap;
`endif
        test_zero_length;
        test_stop_and_stall;
`ifdef AUTO_RELOAD_EN
        test_auto_reload;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
